// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: resolves memory-busy, jump flush and
// load-use hazards into per-register hold/bubble controls, and keeps perf counters.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_jump_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_clear,
  output logic             id_ex_stall,
  output logic             id_ex_clear,
  output logic             ex_mem_stall,
  output logic             mem_wb_clear,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int FC_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic busy, luh;
  logic pc_stall_c, if_id_stall_c, if_id_clear_c, id_ex_stall_c;
  logic id_ex_clear_c, ex_mem_stall_c, mem_wb_clear_c;

  assign busy = mem_req & ~mem_ready;
  assign luh  = ex_mem_read & (ex_rd != 5'd0) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_clear_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_clear_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_wb_clear_c = 1'b0;
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    flush_events_d = flush_events_q;

    if (busy) begin
      // Freeze everything upstream of MEM; a pending jump or load-use simply waits.
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_clear_c = 1'b1;
      if (wait_cnt_q != WC_W'(MEM_TIMEOUT)) wait_cnt_d = wait_cnt_q + WC_W'(1);
      if (wait_cnt_d == WC_W'(MEM_TIMEOUT)) mem_timeout_d = 1'b1;
    end else begin
      wait_cnt_d = '0;
      if (state_q == ST_FLUSH) begin
        if_id_clear_c = 1'b1;
        flush_cnt_d   = flush_cnt_q - FC_W'(1);
        if (flush_cnt_q == FC_W'(1)) state_d = ST_RUN;
      end else if (ex_jump_en) begin
        if_id_clear_c = 1'b1;
        id_ex_clear_c = 1'b1;
        if (flush_events_q != '1) flush_events_d = flush_events_q + CNT_W'(1);
        if (FLUSH_CYCLES > 0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_W'(FLUSH_CYCLES);
        end
      end else if (luh) begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        id_ex_clear_c = 1'b1;
      end
    end

    stall_cycles_d = stall_cycles_q;
    if (pc_stall_c && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      flush_cnt_q    <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  // Controls are gated by reset so the pipeline sees no stray hold/bubble while held in reset.
  assign pc_stall     = pc_stall_c     & rst_n;
  assign if_id_stall  = if_id_stall_c  & rst_n;
  assign if_id_clear  = if_id_clear_c  & rst_n;
  assign id_ex_stall  = id_ex_stall_c  & rst_n;
  assign id_ex_clear  = id_ex_clear_c  & rst_n;
  assign ex_mem_stall = ex_mem_stall_c & rst_n;
  assign mem_wb_clear = mem_wb_clear_c & rst_n;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; two instances with different parameters
// share stimulus and are checked against a behavioural model through a scoreboard queue.
module tb_hazard_ctrl;

  localparam int A_FC = 1, A_MT = 4, A_CW = 32;
  localparam int B_FC = 3, B_MT = 6, B_CW = 4;
  localparam longint A_MAX = (64'd1 << A_CW) - 1;
  localparam longint B_MAX = (64'd1 << B_CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_jump_en = 0;
  logic mem_req = 0, mem_ready = 0;

  logic a_pc, a_ifs, a_ifc, a_ides, a_idec, a_exms, a_mwbc, a_tmo;
  logic [A_CW-1:0] a_sc, a_fe;
  logic b_pc, b_ifs, b_ifc, b_ides, b_idec, b_exms, b_mwbc, b_tmo;
  logic [B_CW-1:0] b_sc, b_fe;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(A_FC), .MEM_TIMEOUT(A_MT), .CNT_W(A_CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_jump_en(ex_jump_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(a_pc), .if_id_stall(a_ifs), .if_id_clear(a_ifc), .id_ex_stall(a_ides),
    .id_ex_clear(a_idec), .ex_mem_stall(a_exms), .mem_wb_clear(a_mwbc),
    .mem_timeout(a_tmo), .stall_cycles(a_sc), .flush_events(a_fe));

  hazard_ctrl #(.FLUSH_CYCLES(B_FC), .MEM_TIMEOUT(B_MT), .CNT_W(B_CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_jump_en(ex_jump_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(b_pc), .if_id_stall(b_ifs), .if_id_clear(b_ifc), .id_ex_stall(b_ides),
    .id_ex_clear(b_idec), .ex_mem_stall(b_exms), .mem_wb_clear(b_mwbc),
    .mem_timeout(b_tmo), .stall_cycles(b_sc), .flush_events(b_fe));

  // Output bit order: pc_stall, if_id_stall, if_id_clear, id_ex_stall, id_ex_clear,
  // ex_mem_stall, mem_wb_clear, mem_timeout.
  typedef struct {
    logic [7:0] o_a, o_b;
    longint sc_a, fe_a, sc_b, fe_b;
    string tag;
  } exp_t;

  typedef struct {
    int flush_left;
    int busy_run;
    bit tmo;
    longint sc, fe;
  } mdl_t;

  exp_t exp_q[$];
  mdl_t ma, mb;
  int n_chk = 0, n_pass = 0;
  string cur_tag = "reset";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // Model outputs from the rules: busy wins, then an active flush window, then jump, then load-use.
  function automatic logic [7:0] mdl_out(input mdl_t m);
    bit busy, hit;
    if (!rst_n) return 8'h00;
    busy = mem_req && !mem_ready;
    hit  = ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (busy)                 return {8'b1101_0110} | {7'b0, m.tmo};
    if (m.flush_left > 0)     return {8'b0010_0000} | {7'b0, m.tmo};
    if (ex_jump_en)           return {8'b0010_1000} | {7'b0, m.tmo};
    if (hit)                  return {8'b1100_1000} | {7'b0, m.tmo};
    return {7'b0, m.tmo};
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int fc, input int mt,
                                    input longint cmax, input logic [7:0] o);
    mdl_t n = m;
    if (mem_req && !mem_ready) begin
      n.busy_run = (m.busy_run + 1 > mt) ? mt : m.busy_run + 1;
      if (n.busy_run >= mt) n.tmo = 1'b1;
    end else begin
      n.busy_run = 0;
      if (m.flush_left > 0) n.flush_left = m.flush_left - 1;
      else if (ex_jump_en) begin
        n.fe = (m.fe < cmax) ? m.fe + 1 : cmax;
        n.flush_left = fc;
      end
    end
    if (o[7]) n.sc = (m.sc < cmax) ? m.sc + 1 : cmax;
    return n;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.flush_left = 0; m.busy_run = 0; m.tmo = 0; m.sc = 0; m.fe = 0;
    return m;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.o_a = mdl_out(ma); e.o_b = mdl_out(mb);
    e.sc_a = ma.sc; e.fe_a = ma.fe; e.sc_b = mb.sc; e.fe_b = mb.fe;
    e.tag = cur_tag;
    exp_q.push_back(e);
  endtask

  // One cycle: drive after the falling edge, queue the expectation, advance the model past the rising edge.
  task automatic drive(input bit r, input bit req, input bit rdy, input bit jmp, input bit mr,
                       input int rd, input int rs1, input bit u1, input int rs2, input bit u2);
    logic [7:0] oa, ob;
    @(negedge clk);
    rst_n = r; mem_req = req; mem_ready = rdy; ex_jump_en = jmp; ex_mem_read = mr;
    ex_rd = 5'(rd); id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    if (!r) begin ma = mdl_reset(); mb = mdl_reset(); end
    #2;
    push_expect();
    oa = mdl_out(ma); ob = mdl_out(mb);
    if (r) begin
      ma = mdl_step(ma, A_FC, A_MT, A_MAX, oa);
      mb = mdl_step(mb, B_FC, B_MT, B_MAX, ob);
    end
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the scoreboard holds against the DUTs, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " a.ctl"}, {56'b0, a_pc, a_ifs, a_ifc, a_ides, a_idec, a_exms, a_mwbc, a_tmo}, {56'b0, e.o_a});
        check({e.tag, " b.ctl"}, {56'b0, b_pc, b_ifs, b_ifc, b_ides, b_idec, b_exms, b_mwbc, b_tmo}, {56'b0, e.o_b});
        check({e.tag, " a.stall_cycles"}, {32'b0, a_sc}, e.sc_a);
        check({e.tag, " a.flush_events"}, {32'b0, a_fe}, e.fe_a);
        check({e.tag, " b.stall_cycles"}, {60'b0, b_sc}, e.sc_b);
        check({e.tag, " b.flush_events"}, {60'b0, b_fe}, e.fe_b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ma = mdl_reset(); mb = mdl_reset();
    cur_tag = "reset";
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1, 5, 5, 1, 0, 0);

    cur_tag = "load_use";
    drive(1, 0, 0, 0, 1, 5, 5, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 5, 5, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 7, 0, 0, 7, 1);
    idle();

    cur_tag = "jump";
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 3, 3, 1, 0, 0);
    repeat (4) idle();

    cur_tag = "mem_wait";
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    cur_tag = "busy_defer";
    repeat (2) drive(1, 1, 0, 1, 1, 4, 4, 1, 0, 0);
    drive(1, 1, 1, 1, 1, 4, 4, 1, 0, 0);
    repeat (4) idle();

    cur_tag = "timeout";
    repeat (6) drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) idle();

    cur_tag = "reset_mid_flush";
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    ma = mdl_reset(); mb = mdl_reset();
    #1;
    push_expect();
    drive(0, 0, 0, 1, 1, 2, 2, 1, 0, 0);
    repeat (3) idle();

    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 9) < 3), $urandom_range(0, 1),
            ($urandom_range(0, 99) < 15), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 9) < 7),
            $urandom_range(0, 3), ($urandom_range(0, 9) < 7));
    end

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
